// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
//   Registered 32-bit integer ALU for the execute stage. Add/sub (trapping and
//   non-trapping), bitwise logic, logical shifts by an immediate amount and
//   signed/unsigned set-less-than. Operands are sampled on the rising edge of
//   clk; Result and OverFlow are valid one cycle later and are reloaded on
//   every edge.
//
// Ports
//   clk       in   1   system clock
//   rst       in   1   synchronous active-high reset (clears Result/OverFlow)
//   A         in   32  first operand (rs)
//   B         in   32  second operand (rt), also the shifted operand
//   ALUOp     in   4   operation select
//   Shamt     in   5   shift amount
//   Result    out  32  registered result
//   OverFlow  out  1   registered signed-overflow flag (Add/Sub only)
// -----------------------------------------------------------------------------
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUOp,
    input  logic [4:0]  Shamt,
    output logic [31:0] Result,
    output logic        OverFlow
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

    logic [31:0] sum;
    logic [32:0] diff;
    logic        add_of;
    logic        sub_of;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [31:0] result_next;
    logic        overflow_next;

    // The subtractor is one bit wider so its top bit is the borrow, which
    // gives the unsigned compare for free.
    assign sum  = A + B;
    assign diff = {1'b0, A} - {1'b0, B};

    assign add_of = (A[31] == B[31]) && (sum[31] != A[31]);
    assign sub_of = (A[31] != B[31]) && (diff[31] != A[31]);

    // Signed less-than is the sign of A-B, corrected when that sign was
    // flipped by overflow.
    assign lt_signed   = diff[31] ^ sub_of;
    assign lt_unsigned = diff[32];

    always_comb begin
        result_next   = 32'd0;
        overflow_next = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                result_next   = sum;
                overflow_next = add_of;
            end
            OP_ADDU: result_next = sum;
            OP_SUB: begin
                result_next   = diff[31:0];
                overflow_next = sub_of;
            end
            OP_SUBU: result_next = diff[31:0];
            OP_AND:  result_next = A & B;
            OP_OR:   result_next = A | B;
            OP_NOR:  result_next = ~(A | B);
            OP_XOR:  result_next = A ^ B;
            OP_SLL:  result_next = B << Shamt;
            OP_SRL:  result_next = B >> Shamt;
            OP_SLT:  result_next = {31'd0, lt_signed};
            OP_SLTU: result_next = {31'd0, lt_unsigned};
            default: begin
                result_next   = 32'd0;
                overflow_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Result   <= 32'd0;
            OverFlow <= 1'b0;
        end else begin
            Result   <= result_next;
            OverFlow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
//   Drives directed vectors into alu_unit. A reference model, written with
//   plain 64-bit signed/unsigned arithmetic, predicts the outputs on every
//   edge and is checked every cycle; hand-computed literal vectors pin the
//   model itself.
// -----------------------------------------------------------------------------
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic [4:0]  Shamt;
    logic [31:0] Result;
    logic        OverFlow;

    int errors = 0;
    int checks = 0;

    alu_unit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .Shamt    (Shamt),
        .Result   (Result),
        .OverFlow (OverFlow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic in 64-bit integers, overflow judged by range.
    function automatic void model(input logic r, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh,
                                  output logic [31:0] res, output logic of);
        longint sa, sb, s, max32, min32;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        max32 = (longint'(1) << 31) - 1;
        min32 = -(longint'(1) << 31);
        res   = 32'd0;
        of    = 1'b0;
        if (!r) begin
            case (op)
                4'd0:  begin s = sa + sb; res = s[31:0]; of = (s > max32) || (s < min32); end
                4'd1:  begin s = sa + sb; res = s[31:0]; end
                4'd2:  begin s = sa - sb; res = s[31:0]; of = (s > max32) || (s < min32); end
                4'd3:  begin s = sa - sb; res = s[31:0]; end
                4'd4:  res = a & b;
                4'd5:  res = a | b;
                4'd6:  res = ~(a | b);
                4'd7:  res = a ^ b;
                4'd8:  res = b << sh;
                4'd9:  res = b >> sh;
                4'd10: res = (sa < sb) ? 32'd1 : 32'd0;
                4'd11: res = (a < b) ? 32'd1 : 32'd0;
                default: begin res = 32'd0; of = 1'b0; end
            endcase
        end
    endfunction

    // Per-cycle compare against the model, using inputs seen at the edge.
    always @(posedge clk) begin
        logic [31:0] exp_res;
        logic        exp_of;
        model(rst, ALUOp, A, B, Shamt, exp_res, exp_of);
        #1;
        checks++;
        if (Result !== exp_res || OverFlow !== exp_of) begin
            errors++;
            $display("FAIL model op=%0d a=%h b=%h sh=%0d: got %h/%b expected %h/%b",
                     ALUOp, A, B, Shamt, Result, OverFlow, exp_res, exp_of);
        end
    end

    // Apply one operation before an edge and check the literal expectation
    // just after that edge.
    task automatic apply(input string name, input logic r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic exp_of);
        @(negedge clk);
        rst = r; ALUOp = op; A = a; B = b; Shamt = sh;
        @(posedge clk);
        #2;
        checks++;
        if (Result !== exp_res || OverFlow !== exp_of) begin
            errors++;
            $display("FAIL %s: got %h/%b expected %h/%b", name, Result, OverFlow, exp_res, exp_of);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; A = 32'd0; B = 32'd0; ALUOp = 4'd0; Shamt = 5'd0;

        apply("reset_state", 1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);

        // Arithmetic
        apply("add_of",   1'b0, 4'd0, 32'h7fff_fff0, 32'h10, 5'd0, 32'h8000_0000, 1'b1);
        apply("addu",     1'b0, 4'd1, 32'h7fff_fff0, 32'h10, 5'd0, 32'h8000_0000, 1'b0);
        apply("sub",      1'b0, 4'd2, 32'h7fff_fff0, 32'h10, 5'd0, 32'h7fff_ffe0, 1'b0);
        apply("subu",     1'b0, 4'd3, 32'h7fff_fff0, 32'h10, 5'd0, 32'h7fff_ffe0, 1'b0);
        // Logic
        apply("and",      1'b0, 4'd4, 32'h7fff_fff0, 32'h10, 5'd0, 32'h0000_0010, 1'b0);
        apply("or",       1'b0, 4'd5, 32'h7fff_fff0, 32'h10, 5'd0, 32'h7fff_fff0, 1'b0);
        apply("nor",      1'b0, 4'd6, 32'h7fff_fff0, 32'h10, 5'd0, 32'h8000_000f, 1'b0);
        apply("xor",      1'b0, 4'd7, 32'h7fff_fff0, 32'h10, 5'd0, 32'h7fff_ffe0, 1'b0);
        // Shifts and compares
        apply("sll",      1'b0, 4'd8, 32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0100, 1'b0);
        apply("srl",      1'b0, 4'd9, 32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0001, 1'b0);
        apply("slt",      1'b0, 4'd10, 32'h7fff_fff0, 32'h10, 5'd4, 32'h0, 1'b0);
        apply("sltu",     1'b0, 4'd11, 32'h7fff_fff0, 32'h10, 5'd4, 32'h0, 1'b0);
        apply("sll_sh0",  1'b0, 4'd8, 32'h0, 32'hdead_beef, 5'd0, 32'hdead_beef, 1'b0);
        apply("srl_sh31", 1'b0, 4'd9, 32'h0, 32'h8000_0001, 5'd31, 32'h0000_0001, 1'b0);
        // Wraparound and signedness
        apply("add_wrap", 1'b0, 4'd0, 32'hffff_ffff, 32'h1, 5'd0, 32'h0, 1'b0);
        apply("addu_wrap",1'b0, 4'd1, 32'hffff_ffff, 32'h1, 5'd0, 32'h0, 1'b0);
        apply("slt_neg",  1'b0, 4'd10, 32'hffff_ffff, 32'h1, 5'd0, 32'h1, 1'b0);
        apply("sltu_big", 1'b0, 4'd11, 32'hffff_ffff, 32'h1, 5'd0, 32'h0, 1'b0);
        apply("slt_ovf",  1'b0, 4'd10, 32'h8000_0000, 32'h7fff_ffff, 5'd0, 32'h1, 1'b0);
        // Sub overflow and reserved
        apply("sub_of",   1'b0, 4'd2, 32'h8000_0000, 32'h1, 5'd0, 32'h7fff_ffff, 1'b1);
        apply("subu_nof", 1'b0, 4'd3, 32'h8000_0000, 32'h1, 5'd0, 32'h7fff_ffff, 1'b0);
        apply("add_negof",1'b0, 4'd0, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0, 1'b1);
        apply("rsvd14",   1'b0, 4'd14, 32'h1234_5678, 32'h9abc_def0, 5'd3, 32'h0, 1'b0);
        // Reset wins over an overflowing add, then the first edge after
        // release loads the operation.
        apply("rst_wins", 1'b1, 4'd0, 32'h7fff_fff0, 32'h10, 5'd0, 32'h0, 1'b0);
        apply("rst_rel",  1'b0, 4'd0, 32'h7fff_fff0, 32'h10, 5'd0, 32'h8000_0000, 1'b1);
        // Back-to-back, one op per cycle
        apply("b2b_1",    1'b0, 4'd1, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
        apply("b2b_2",    1'b0, 4'd3, 32'd5, 32'd7, 5'd0, 32'hffff_fffe, 1'b0);
        apply("b2b_3",    1'b0, 4'd5, 32'hf0, 32'h0f, 5'd0, 32'hff, 1'b0);

        // Sweep every opcode over a few operand pairs; model checks each edge.
        for (int p = 0; p < 4; p++) begin
            for (int op = 0; op < 16; op++) begin
                @(negedge clk);
                rst   = 1'b0;
                ALUOp = 4'(op);
                case (p)
                    0: begin A = 32'h7fff_ffff; B = 32'hffff_ffff; end
                    1: begin A = 32'h8000_0000; B = 32'h7fff_ffff; end
                    2: begin A = 32'h1234_5678; B = 32'h1234_5678; end
                    default: begin A = 32'h0000_0003; B = 32'hc000_0001; end
                endcase
                Shamt = 5'(op * 2 + p);
            end
        end
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
